// File: rtl/ex_stage.sv
// Execute stage: single-cycle RV64I ALU plus an iterative RV64M multiply/divide
// unit. The output registers form the EX/MEM pipeline register read directly
// by the memory stage.
module ex_stage #(
  parameter int PC_WIDTH     = 64,
  parameter int XLEN         = 64,
  parameter int RA_WIDTH     = 5,
  parameter int EX_CTRL_BITS = 6,
  parameter int M_CTRL_BITS  = 5,
  parameter int WB_CTRL_BITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    valid_in,
  input  logic [PC_WIDTH-1:0]     PC_in,
  input  logic [XLEN-1:0]         rs1_data_in,
  input  logic [XLEN-1:0]         rs2_data_in,
  input  logic [XLEN-1:0]         imm_in,
  input  logic [2:0]              funct3_in,
  input  logic [RA_WIDTH-1:0]     rd_addr_in,
  input  logic [EX_CTRL_BITS-1:0] EX_Ctrl_in,
  input  logic [M_CTRL_BITS-1:0]  M_Ctrl_in,
  input  logic [WB_CTRL_BITS-1:0] WB_Ctrl_in,
  output logic                    stall,
  output logic                    valid_out,
  output logic [XLEN-1:0]         result_out,
  output logic [XLEN-1:0]         rs2_data_out,
  output logic [2:0]              funct3_out,
  output logic [RA_WIDTH-1:0]     rd_addr_out,
  output logic [M_CTRL_BITS-1:0]  M_Ctrl_out,
  output logic [WB_CTRL_BITS-1:0] WB_Ctrl_out
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    return {{(XLEN-32){1'b0}}, v};
  endfunction

  // Execute control decode
  logic alu_src, is_muldiv, alt, is_word, pc_src, force_add;
  assign alu_src   = EX_Ctrl_in[0];
  assign is_muldiv = EX_Ctrl_in[1];
  assign alt       = EX_Ctrl_in[2];
  assign is_word   = EX_Ctrl_in[3];
  assign pc_src    = EX_Ctrl_in[4];
  assign force_add = EX_Ctrl_in[5];

  // ---------------------------------------------------------------- ALU
  logic [XLEN-1:0] op_a, op_b, alu_raw, alu_result;
  logic [SH_W-1:0] shamt;

  // Single-cycle ALU; word ops compute on the low half and sign-extend bit 31.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    alu_raw = '0;
    op_a    = pc_src ? XLEN'(PC_in) : rs1_data_in;
    op_b    = alu_src ? imm_in : rs2_data_in;
    shamt   = is_word ? SH_W'(op_b[4:0]) : op_b[SH_W-1:0];
    if (force_add) begin
      alu_raw = op_a + op_b;
    end else begin
      case (funct3_in)
        3'b000: alu_raw = alt ? (op_a - op_b) : (op_a + op_b);
        3'b001: alu_raw = op_a << shamt;
        3'b010: alu_raw = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        3'b011: alu_raw = {{(XLEN-1){1'b0}}, (op_a < op_b)};
        3'b100: alu_raw = op_a ^ op_b;
        3'b101: begin
          if (is_word && alt)  alu_raw = $signed(sext32(op_a[31:0])) >>> shamt;
          else if (is_word)    alu_raw = zext32(op_a[31:0]) >> shamt;
          else if (alt)        alu_raw = $signed(op_a) >>> shamt;
          else                 alu_raw = op_a >> shamt;
        end
        3'b110: alu_raw = op_a | op_b;
        default: alu_raw = op_a & op_b;
      endcase
    end
    alu_result = is_word ? sext32(alu_raw[31:0]) : alu_raw;
  end

  // ---------------------------------------------------------- mul / div
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] prod;        // mul: {acc, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   b_mag_q;     // multiplicand or divisor magnitude
  logic              corner_q;
  logic [XLEN-1:0]   corner_res;

  logic              md_is_div, a_signed, b_signed, a_neg, b_neg;
  logic              div_zero, div_ovf, md_last;
  logic [XLEN-1:0]   md_a, md_b, a_mag, b_mag, min_neg, corner_val;
  logic [XLEN:0]     mul_sum, div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] prod_next, mul_full, mul_s;
  logic [XLEN-1:0]   q_fix, r_fix, md_raw, md_result;

  // Operand conditioning, corner detection, one iteration step and sign fix-up.
  always_comb begin
    md_is_div = funct3_in[2];
    a_signed  = 1'b0;
    b_signed  = 1'b0;
    case (funct3_in)
      3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:                 a_signed = 1'b1;
      default: ;
    endcase

    md_a  = is_word ? (a_signed ? sext32(rs1_data_in[31:0]) : zext32(rs1_data_in[31:0])) : rs1_data_in;
    md_b  = is_word ? (b_signed ? sext32(rs2_data_in[31:0]) : zext32(rs2_data_in[31:0])) : rs2_data_in;
    a_neg = a_signed & md_a[XLEN-1];
    b_neg = b_signed & md_b[XLEN-1];
    a_mag = a_neg ? -md_a : md_a;
    b_mag = b_neg ? -md_b : md_b;

    min_neg  = is_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (md_b == '0);
    div_ovf  = a_signed && (md_a == min_neg) && (md_b == '1);
    if (div_zero) corner_val = funct3_in[1] ? md_a : '1;
    else          corner_val = funct3_in[1] ? '0   : md_a;

    // Shift-add step: add multiplicand to the upper half when the multiplier LSB is set.
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, b_mag_q} : '0);
    // Restoring step: shift {rem, quo} left and subtract the divisor if it fits.
    div_shift = prod[2*XLEN-1:XLEN-1];
    div_ge    = (div_shift >= {1'b0, b_mag_q});
    div_rem   = div_ge ? XLEN'(div_shift - {1'b0, b_mag_q}) : div_shift[XLEN-1:0];
    prod_next = md_is_div ? {div_rem, prod[XLEN-2:0], div_ge} : {mul_sum, prod[XLEN-1:1]};
    md_last   = (cnt == (is_word ? CNT_W'(31) : CNT_W'(XLEN-1)));

    // Word multiplies run 32 iterations, leaving the product 32 bits higher.
    mul_full = is_word ? (prod >> 32) : prod;
    mul_s    = (a_neg ^ b_neg) ? -mul_full : mul_full;
    q_fix    = (a_neg ^ b_neg) ? -prod[XLEN-1:0] : prod[XLEN-1:0];
    r_fix    = a_neg ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];

    if (corner_q)             md_raw = corner_res;
    else if (md_is_div)       md_raw = funct3_in[1] ? r_fix : q_fix;
    else if (funct3_in == '0) md_raw = mul_s[XLEN-1:0];
    else                      md_raw = mul_s[2*XLEN-1:XLEN];
    md_result = is_word ? sext32(md_raw[31:0]) : md_raw;
  end

  // Hold the front of the pipe while a mul/div is being accepted or iterating.
  assign stall = !rst && !flush &&
                 (((state == S_IDLE) && valid_in && is_muldiv) || (state == S_BUSY));

  // Mul/div sequencer: IDLE -> BUSY (XLEN or 32 iterations) -> DONE, or IDLE -> DONE on corners.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      // NOTE: the iteration datapath is reset too so a post-reset result never depends on stale state.
      prod       <= '0;
      b_mag_q    <= '0;
      corner_q   <= 1'b0;
      corner_res <= '0;
    end else if (flush) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_in && is_muldiv) begin
            cnt <= '0;
            if (md_is_div && (div_zero || div_ovf)) begin
              corner_q   <= 1'b1;
              corner_res <= corner_val;
              state      <= S_DONE;
            end else begin
              corner_q <= 1'b0;
              b_mag_q  <= b_mag;
              prod     <= {{XLEN{1'b0}}, ((md_is_div && is_word) ? (a_mag << 32) : a_mag)};
              state    <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          prod <= prod_next;
          cnt  <= cnt + 1'b1;
          if (md_last) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // EX/MEM register: real instructions pass through, stalls/flushes/bubbles insert a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out    <= 1'b0;
      result_out   <= '0;
      rs2_data_out <= '0;
      funct3_out   <= '0;
      rd_addr_out  <= '0;
      M_Ctrl_out   <= '0;
      WB_Ctrl_out  <= '0;
    end else begin
      result_out   <= is_muldiv ? md_result : alu_result;
      rs2_data_out <= rs2_data_in;
      funct3_out   <= funct3_in;
      rd_addr_out  <= rd_addr_in;
      if (valid_in && !flush && !stall) begin
        valid_out   <= 1'b1;
        M_Ctrl_out  <= M_Ctrl_in;
        WB_Ctrl_out <= WB_Ctrl_in;
      end else begin
        valid_out   <= 1'b0;
        M_Ctrl_out  <= '0;
        WB_Ctrl_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: table of single-cycle ALU vectors, then
// hand-written mul/div, flush and reset sequences.
module tb_ex_stage;

  localparam logic [5:0] C_SRC = 6'b000001;
  localparam logic [5:0] C_MD  = 6'b000010;
  localparam logic [5:0] C_ALT = 6'b000100;
  localparam logic [5:0] C_W   = 6'b001000;
  localparam logic [5:0] C_PC  = 6'b010000;
  localparam logic [5:0] C_FA  = 6'b100000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, flush, valid_in;
  logic [63:0] PC_in, rs1_data_in, rs2_data_in, imm_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_addr_in;
  logic [5:0]  EX_Ctrl_in;
  logic [4:0]  M_Ctrl_in, WB_Ctrl_in;
  logic        stall, valid_out;
  logic [63:0] result_out, rs2_data_out;
  logic [2:0]  funct3_out;
  logic [4:0]  rd_addr_out, M_Ctrl_out, WB_Ctrl_out;

  ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .PC_in(PC_in),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in), .imm_in(imm_in),
    .funct3_in(funct3_in), .rd_addr_in(rd_addr_in), .EX_Ctrl_in(EX_Ctrl_in),
    .M_Ctrl_in(M_Ctrl_in), .WB_Ctrl_in(WB_Ctrl_in), .stall(stall),
    .valid_out(valid_out), .result_out(result_out), .rs2_data_out(rs2_data_out),
    .funct3_out(funct3_out), .rd_addr_out(rd_addr_out), .M_Ctrl_out(M_Ctrl_out),
    .WB_Ctrl_out(WB_Ctrl_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] rs1, rs2, imm, pc;
    logic [2:0]  f3;
    logic [5:0]  ctrl;
    logic [63:0] exp;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  // One mul/div op: count stall cycles, confirm bubbles, then the result edge and the one-shot valid.
  task automatic run_md(input string name, input logic [2:0] f3, input logic word,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_stall);
    int n;
    int bubble_err;
    @(negedge clk);
    valid_in    = 1'b1;
    rs1_data_in = a;
    rs2_data_in = b;
    imm_in      = 64'h0;
    funct3_in   = f3;
    rd_addr_in  = 5'd9;
    EX_Ctrl_in  = C_MD | (word ? C_W : 6'b0);
    M_Ctrl_in   = 5'h11;
    WB_Ctrl_in  = 5'h03;
    #1;
    n = 0;
    bubble_err = 0;
    while (stall === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      if (valid_out !== 1'b0 || M_Ctrl_out !== 5'h0 || WB_Ctrl_out !== 5'h0) bubble_err++;
      n++;
    end
    check({name, " stall cycles"}, 64'(n), 64'(exp_stall));
    check({name, " bubbles"}, 64'(bubble_err), 64'd0);
    @(posedge clk); #1;
    check({name, " valid"}, 64'(valid_out), 64'd1);
    check({name, " result"}, result_out, exp);
    check({name, " wb ctrl"}, 64'(WB_Ctrl_out), 64'h03);
    @(negedge clk);
    valid_in   = 1'b0;
    EX_Ctrl_in = 6'b0;
    @(posedge clk); #1;
    check({name, " one-shot"}, 64'(valid_out), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{64'd5, 64'd7, 64'd0, 64'd0, 3'b000, 6'b0, 64'd12};
    vecs[1]  = '{64'd5, 64'd7, 64'd0, 64'd0, 3'b000, C_ALT, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[2]  = '{64'h7FFF_FFFF, 64'd0, 64'd1, 64'd0, 3'b000, C_SRC | C_W, 64'hFFFF_FFFF_8000_0000};
    vecs[3]  = '{64'd1, 64'd63, 64'd0, 64'd0, 3'b001, 6'b0, 64'h8000_0000_0000_0000};
    vecs[4]  = '{64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'd0, 3'b101, C_ALT, 64'hF800_0000_0000_0000};
    vecs[5]  = '{64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'd0, 3'b101, 6'b0, 64'h0800_0000_0000_0000};
    vecs[6]  = '{ONES, 64'd1, 64'd0, 64'd0, 3'b010, 6'b0, 64'd1};
    vecs[7]  = '{ONES, 64'd1, 64'd0, 64'd0, 3'b011, 6'b0, 64'd0};
    vecs[8]  = '{64'hF0F0, 64'hFF00, 64'd0, 64'd0, 3'b100, 6'b0, 64'h0FF0};
    vecs[9]  = '{64'hF0F0, 64'h0F00, 64'd0, 64'd0, 3'b110, 6'b0, 64'hFFF0};
    vecs[10] = '{64'hF0F0, 64'hFF00, 64'd0, 64'd0, 3'b111, 6'b0, 64'hF000};
    vecs[11] = '{64'h1000, 64'd0, 64'h20, 64'd0, 3'b010, C_SRC | C_FA, 64'h1020};
    vecs[12] = '{64'hDEAD, 64'd0, 64'h1000, 64'h4000, 3'b000, C_PC | C_SRC | C_FA, 64'h5000};
    vecs[13] = '{64'h8000_0000, 64'd4, 64'd0, 64'd0, 3'b101, C_W | C_ALT, 64'hFFFF_FFFF_F800_0000};
    vecs[14] = '{64'h8000_0000, 64'd4, 64'd0, 64'd0, 3'b101, C_W, 64'h0000_0000_0800_0000};
    vecs[15] = '{64'd1, 64'h3F, 64'd0, 64'd0, 3'b001, C_W, 64'hFFFF_FFFF_8000_0000};
    vecs[16] = '{64'd1, 64'h41, 64'd0, 64'd0, 3'b001, 6'b0, 64'd2};
    vecs[17] = '{64'd0, 64'd1, 64'd0, 64'd0, 3'b000, C_W | C_ALT, ONES};
    vecs[18] = '{64'd5, 64'd7, 64'd0, 64'd0, 3'b000, C_ALT | C_FA, 64'd12};
    vecs[19] = '{64'd10, 64'd999, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 3'b000, C_SRC, 64'd7};

    // Reset with a mul/div presented: stall must stay low and outputs zero.
    rst = 1'b1; flush = 1'b0; valid_in = 1'b1;
    PC_in = 64'h0; rs1_data_in = 64'd3; rs2_data_in = 64'd4; imm_in = 64'h0;
    funct3_in = 3'b000; rd_addr_in = 5'd1; EX_Ctrl_in = C_MD;
    M_Ctrl_in = 5'h1F; WB_Ctrl_in = 5'h1F;
    repeat (2) @(posedge clk);
    #1;
    check("reset stall", 64'(stall), 64'd0);
    check("reset valid", 64'(valid_out), 64'd0);
    check("reset result", result_out, 64'd0);
    check("reset wb", 64'(WB_Ctrl_out), 64'd0);
    @(negedge clk);
    valid_in = 1'b0; EX_Ctrl_in = 6'b0; rst = 1'b0;

    // Single-cycle ALU table.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      valid_in    = 1'b1;
      rs1_data_in = vecs[i].rs1;
      rs2_data_in = vecs[i].rs2;
      imm_in      = vecs[i].imm;
      PC_in       = vecs[i].pc;
      funct3_in   = vecs[i].f3;
      EX_Ctrl_in  = vecs[i].ctrl;
      rd_addr_in  = 5'(i + 1);
      M_Ctrl_in   = 5'h15;
      WB_Ctrl_in  = 5'h0A;
      @(posedge clk); #1;
      check($sformatf("vec%0d result", i), result_out, vecs[i].exp);
      check($sformatf("vec%0d valid", i), 64'(valid_out), 64'd1);
      check($sformatf("vec%0d rd", i), 64'(rd_addr_out), 64'(i + 1));
    end
    check("pass m ctrl", 64'(M_Ctrl_out), 64'h15);
    check("pass rs2", rs2_data_out, 64'd999);

    // Bubble: controls must be zeroed.
    @(negedge clk);
    valid_in = 1'b0; M_Ctrl_in = 5'h1F; WB_Ctrl_in = 5'h1F;
    @(posedge clk); #1;
    check("bubble valid", 64'(valid_out), 64'd0);
    check("bubble m", 64'(M_Ctrl_out), 64'd0);
    check("bubble wb", 64'(WB_Ctrl_out), 64'd0);

    // Mul/div operations.
    run_md("mul",    3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF4, 65);
    run_md("mulhu",  3'b011, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_md("mulh",   3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, ONES, 65);
    run_md("div",    3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_md("rem",    3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65);
    run_md("divu",   3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    run_md("divu0",  3'b101, 1'b0, 64'd5, 64'd0, ONES, 1);
    run_md("rem0",   3'b110, 1'b0, 64'h1234, 64'd0, 64'h1234, 1);
    run_md("divovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1);
    run_md("divw",   3'b100, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_md("mulw",   3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run_md("remuw",  3'b111, 1'b1, 64'h1_0000_0007, 64'd3, 64'd1, 33);

    // Flush at iteration 20 of a DIV, then an ADD must complete in one cycle.
    @(negedge clk);
    valid_in = 1'b1; rs1_data_in = 64'd100; rs2_data_in = 64'd7;
    funct3_in = 3'b100; EX_Ctrl_in = C_MD; M_Ctrl_in = 5'h11; WB_Ctrl_in = 5'h03;
    repeat (21) @(posedge clk);
    #1;
    check("flush pre stall", 64'(stall), 64'd1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush stall drop", 64'(stall), 64'd0);
    @(posedge clk); #1;
    check("flush valid", 64'(valid_out), 64'd0);
    check("flush wb", 64'(WB_Ctrl_out), 64'd0);
    @(negedge clk);
    flush = 1'b0; rs1_data_in = 64'd5; rs2_data_in = 64'd7;
    funct3_in = 3'b000; EX_Ctrl_in = 6'b0;
    #1;
    check("post flush stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    check("post flush add", result_out, 64'd12);
    check("post flush valid", 64'(valid_out), 64'd1);

    // Asynchronous reset in the middle of a MUL.
    @(negedge clk);
    rs1_data_in = 64'd3; rs2_data_in = 64'd5; rd_addr_in = 5'd7;
    funct3_in = 3'b000; EX_Ctrl_in = C_MD;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid rst stall", 64'(stall), 64'd0);
    check("mid rst valid", 64'(valid_out), 64'd0);
    check("mid rst result", result_out, 64'd0);
    check("mid rst rs2", rs2_data_out, 64'd0);
    check("mid rst rd", 64'(rd_addr_out), 64'd0);
    check("mid rst funct3", 64'(funct3_out), 64'd0);
    @(negedge clk);
    valid_in = 1'b0; EX_Ctrl_in = 6'b0; rst = 1'b0;
    run_md("mul after rst", 3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF4, 65);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage that consumes the ID/EX pipeline register outputs and produces the EX/MEM pipeline register contents.
- Single-cycle RV64I ALU for ordinary operations.
- Iterative multiply/divide unit for RV64M operations, which holds the front of the pipeline with a stall signal while it works.
- Output register in this block is the EX/MEM register; the next stage reads it directly.

Parameters:
PC_WIDTH, 64, program counter width
XLEN, 64, datapath width; mul/div iteration count
RA_WIDTH, 5, register address width
EX_CTRL_BITS, 6, execute control width
M_CTRL_BITS, 5, memory control width (passed through, opaque)
WB_CTRL_BITS, 5, writeback control width (passed through, opaque)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous kill of the current op (branch mispredict)
valid_in  in  1  ID/EX holds a real instruction
PC_in  in  PC_WIDTH  instruction PC
rs1_data_in  in  XLEN  operand rs1
rs2_data_in  in  XLEN  operand rs2 / store data
imm_in  in  XLEN  sign-extended immediate
funct3_in  in  3  funct3
rd_addr_in  in  RA_WIDTH  destination register
EX_Ctrl_in  in  EX_CTRL_BITS  bit0 alu_src (1=imm), bit1 is_muldiv, bit2 alt (SUB/SRA), bit3 is_word, bit4 pc_src (A=PC), bit5 force_add
M_Ctrl_in  in  M_CTRL_BITS  memory controls
WB_Ctrl_in  in  WB_CTRL_BITS  writeback controls
stall  out  1  hold IF/ID and ID/EX stable (combinational)
valid_out  out  1  EX/MEM holds a real instruction
result_out  out  XLEN  ALU or mul/div result / memory address
rs2_data_out  out  XLEN  store data
funct3_out  out  3  passthrough
rd_addr_out  out  RA_WIDTH  passthrough
M_Ctrl_out  out  M_CTRL_BITS  passthrough
WB_Ctrl_out  out  WB_CTRL_BITS  passthrough

Behaviour:
- Reset: every output register 0; stall 0; mul/div FSM IDLE, iteration counter 0.
- Operand A is PC_in zero-extended if pc_src=1, else rs1. Operand B is imm if alu_src=1, else rs2.
- ALU op select:
  - force_add=1: ADD.
  - Otherwise by funct3: 000 ADD (SUB if alt), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if alt), 110 OR, 111 AND.
  - Shift amount is B[5:0], or B[4:0] when is_word.
- is_word:
  - Operations are performed on the low 32 bits.
  - Result is sign-extended from bit 31.
  - For W div/rem, operands are sign- or zero-extended from bit 31 per funct3.
- Plain op with valid_in=1 and no flush: 1-cycle latency. All outputs are captured at the next edge and valid_out=1.
- valid_in=0: the bubble is captured (valid_out=0, M_Ctrl_out=0, WB_Ctrl_out=0); data outputs don't-care.
- Mul/div funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Mul/div implementation: shift-add multiplier with a 2*XLEN product, and restoring divider on magnitudes with signs fixed at the end.
- Mul/div FSM:
  - IDLE:
    - Entered with valid_in & is_muldiv & !flush.
    - Asserts stall=1.
    - Goes to DONE if divisor==0 or signed overflow (most-negative / -1); otherwise loads operands and goes to BUSY.
  - BUSY:
    - stall=1 for exactly XLEN cycles (32 if is_word); counter increments each cycle.
    - Goes to DONE on the last iteration.
  - DONE:
    - stall=0; the result is driven to the output path and captured at this edge with valid_out=1.
    - FSM returns to IDLE at the same edge, so the same op is not restarted.
  - Total stall for 64-bit mul/div is XLEN+1 = 65 cycles; the result is visible at the outputs 66 edges after the op was first presented.
- Corner cases:
  - Divide by zero: quotient all ones, remainder = dividend.
  - Signed overflow: quotient = dividend, remainder = 0.
  - Both corner cases hold stall for 1 cycle only.
- While stall=1: EX/MEM captures a bubble each cycle (valid_out=0, controls 0).
- Upstream must hold all inputs stable while stall=1; this block does not re-latch operands during BUSY.
- flush:
  - Overrides everything: stall=0 combinationally in that cycle.
  - At the next edge the FSM goes to IDLE, the counter clears, and a bubble is captured.
- rst mid-operation: FSM is aborted immediately and all outputs go to 0.

Test Plan:
- ADD/SUB: rs1=5, rs2=7, alt=0 -> result_out=12, valid_out=1 one edge later. Same with alt=1 -> 0xFFFF_FFFF_FFFF_FFFE.
- ADDIW wrap: rs1=0x7FFF_FFFF, imm=1, alu_src=1, is_word=1 -> result_out=0xFFFF_FFFF_8000_0000.
- MUL 3*-4 -> stall high for exactly 65 cycles with bubbles on the outputs, then result_out=0xFFFF_FFFF_FFFF_FFF4 with valid_out=1 for one cycle. MULHU 0xFFFF_FFFF_FFFF_FFFF^2 -> 0xFFFF_FFFF_FFFF_FFFE.
- DIV -7/2 -> quotient -3, REM -7/2 -> remainder -1. DIVU x/0 -> all ones with 1 stall cycle. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000 with 1 stall cycle.
- flush at iteration 20 of a DIV -> stall drops the same cycle, valid_out=0 next edge, and a following ADD completes normally in 1 cycle.
- rst asserted mid-BUSY asynchronously -> all outputs 0 and stall 0 immediately; a MUL issued after rst release completes with the correct value.
